// File: rtl/operand_fetch_pkg.sv
// Shared widths and held-instruction layout for the decode-to-execute operand stage.
package operand_fetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned NUM_REGS = 2 ** AW;
  localparam int unsigned CTRL_W   = 64;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } slot_e;

  typedef struct packed {
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic [AW-1:0]     rd;
    logic              rd_wen;
    logic [CTRL_W-1:0] ctrl;
  } held_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-writer bit vector: one bit per architectural register, x0 never pending.
module of_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_set,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr,
  input  logic [AW-1:0] i_clr_addr,
  input  logic [AW-1:0] i_rs1_addr,
  input  logic [AW-1:0] i_rs2_addr,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rs1_pend,
  output logic          o_rs2_pend,
  output logic          o_rd_pend
);

  logic [NUM_REGS-1:0] r_pending;

  // Set is written after clear so a same-edge set/clear on one address leaves it pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      if (i_clr && (i_clr_addr != '0)) r_pending[i_clr_addr] <= 1'b0;
      if (i_set && (i_set_addr != '0)) r_pending[i_set_addr] <= 1'b1;
    end
  end

  assign o_rs1_pend = (i_rs1_addr != '0) & r_pending[i_rs1_addr];
  assign o_rs2_pend = (i_rs2_addr != '0) & r_pending[i_rs2_addr];
  assign o_rd_pend  = (i_rd_addr  != '0) & r_pending[i_rd_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand stage: drives the sync-read register file, bypasses same-edge writeback,
// and stalls RAW/WAW hazards using a pending-writer scoreboard.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [AW-1:0]     id_rs1_addr,
  input  logic [AW-1:0]     id_rs2_addr,
  input  logic [AW-1:0]     id_rd_addr,
  input  logic              id_rd_wen,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [AW-1:0]     rf_rs1_addr,
  output logic [AW-1:0]     rf_rs2_addr,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic              wb_wen,
  input  logic [AW-1:0]     wb_waddr,
  input  logic [XLEN-1:0]   wb_wdata,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [AW-1:0]     ex_rd_addr,
  output logic              ex_rd_wen,
  output logic [CTRL_W-1:0] ex_ctrl
);

  slot_e           r_state;
  held_t           r_held;
  logic            r_byp1_v;
  logic            r_byp2_v;
  logic [XLEN-1:0] r_byp1_d;
  logic [XLEN-1:0] r_byp2_d;

  logic w_s_valid;
  logic w_hazard;
  logic w_ex_fire;
  logic w_accept;
  logic w_rs1_pend;
  logic w_rs2_pend;
  logic w_rd_pend;

  of_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set      (w_ex_fire & r_held.rd_wen),
    .i_set_addr (r_held.rd),
    .i_clr      (wb_wen),
    .i_clr_addr (wb_waddr),
    .i_rs1_addr (r_held.rs1),
    .i_rs2_addr (r_held.rs2),
    .i_rd_addr  (r_held.rd),
    .o_rs1_pend (w_rs1_pend),
    .o_rs2_pend (w_rs2_pend),
    .o_rd_pend  (w_rd_pend)
  );

  assign w_s_valid = (r_state == HOLD);
  assign w_hazard  = w_rs1_pend | w_rs2_pend | (r_held.rd_wen & w_rd_pend);
  assign ex_valid  = w_s_valid & ~w_hazard;
  assign w_ex_fire = ex_valid & ex_ready;
  assign id_ready  = ~w_s_valid | w_ex_fire;
  assign w_accept  = id_valid & id_ready & ~flush;

  // The held address is re-presented while stalled so register-file data keeps refreshing.
  assign rf_rs1_addr = w_accept ? id_rs1_addr : r_held.rs1;
  assign rf_rs2_addr = w_accept ? id_rs2_addr : r_held.rs2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_held  <= '0;
    end else begin
      if (flush)          r_state <= EMPTY;
      else if (w_accept)  r_state <= HOLD;
      else if (w_ex_fire) r_state <= EMPTY;
      if (w_accept) begin
        r_held <= '{rs1: id_rs1_addr, rs2: id_rs2_addr, rd: id_rd_addr,
                    rd_wen: id_rd_wen, ctrl: id_ctrl};
      end
    end
  end

  // The register file has no write-through, so capture a write landing on the read edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp1_v <= 1'b0;
      r_byp2_v <= 1'b0;
      r_byp1_d <= '0;
      r_byp2_d <= '0;
    end else begin
      r_byp1_v <= wb_wen & (wb_waddr == rf_rs1_addr) & (wb_waddr != '0);
      r_byp2_v <= wb_wen & (wb_waddr == rf_rs2_addr) & (wb_waddr != '0);
      r_byp1_d <= wb_wdata;
      r_byp2_d <= wb_wdata;
    end
  end

  assign ex_rs1_data = (r_held.rs1 == '0) ? '0 : (r_byp1_v ? r_byp1_d : rf_rs1_data);
  assign ex_rs2_data = (r_held.rs2 == '0) ? '0 : (r_byp2_v ? r_byp2_d : rf_rs2_data);
  assign ex_rd_addr  = r_held.rd;
  assign ex_rd_wen   = r_held.rd_wen;
  assign ex_ctrl     = r_held.ctrl;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural register file plus a cycle model of the
// architectural state, pending writers and the single held instruction.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_rd_wen;
  logic [63:0] id_ctrl;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data = '0;
  logic [31:0] rf_rs2_data = '0;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_wen;
  logic [63:0] ex_ctrl;

  int checks = 0;
  int passed = 0;

  // model state
  logic [31:0] arch [32];
  bit          pend [32];
  bit          hv;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  bit          m_wen;
  logic [63:0] m_ctrl;

  // stand-in register file: synchronous read, no write-through, x0 hardwired
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rf_rs1_data <= regs[rf_rs1_addr];
    rf_rs2_data <= regs[rf_rs2_addr];
    if (wb_wen && wb_waddr != 5'd0) regs[wb_waddr] <= wb_wdata;
  end

  operand_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rd_addr  (id_rd_addr),
    .id_rd_wen   (id_rd_wen),
    .id_ctrl     (id_ctrl),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .wb_wen      (wb_wen),
    .wb_waddr    (wb_waddr),
    .wb_wdata    (wb_wdata),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_rd_addr  (ex_rd_addr),
    .ex_rd_wen   (ex_rd_wen),
    .ex_ctrl     (ex_ctrl)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] arch_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : arch[a];
  endfunction

  task automatic model_clear();
    hv = 0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_wen = 0; m_ctrl = '0;
    for (int i = 0; i < 32; i++) pend[i] = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the rising edge.
  task automatic cyc();
    bit hz, ev, ir, acc, fire;
    @(negedge clk);
    hz = hv && ((m_rs1 != 0 && pend[m_rs1]) || (m_rs2 != 0 && pend[m_rs2]) ||
                (m_wen && m_rd != 0 && pend[m_rd]));
    ev  = hv && !hz;
    ir  = !hv || (ev && ex_ready);
    acc = id_valid && ir && !flush;
    check("ex_valid", ex_valid, ev);
    check("id_ready", id_ready, ir);
    check("rf_rs1_addr", rf_rs1_addr, acc ? id_rs1_addr : m_rs1);
    check("rf_rs2_addr", rf_rs2_addr, acc ? id_rs2_addr : m_rs2);
    if (ev) begin
      check("ex_rs1_data", ex_rs1_data, arch_val(m_rs1));
      check("ex_rs2_data", ex_rs2_data, arch_val(m_rs2));
      check("ex_rd_addr", ex_rd_addr, m_rd);
      check("ex_rd_wen", ex_rd_wen, m_wen);
      check("ex_ctrl", ex_ctrl, m_ctrl);
    end
    @(posedge clk);
    fire = ev && ex_ready;
    if (wb_wen && wb_waddr != 0) begin
      pend[wb_waddr] = 0;
      arch[wb_waddr] = wb_wdata;
    end
    if (fire && m_wen && m_rd != 0) pend[m_rd] = 1;
    if (flush) hv = 0;
    else if (acc) begin
      hv = 1; m_rs1 = id_rs1_addr; m_rs2 = id_rs2_addr; m_rd = id_rd_addr;
      m_wen = id_rd_wen; m_ctrl = id_ctrl;
    end else if (fire) hv = 0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_id_ready", id_ready, 1'b1);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic offer(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic wen);
    id_valid = 1'b1; id_rs1_addr = r1; id_rs2_addr = r2; id_rd_addr = rd;
    id_rd_wen = wen; id_ctrl = {$urandom, $urandom};
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_wen = 1'b1; wb_waddr = a; wb_wdata = d;
  endtask

  task automatic idle();
    id_valid = 1'b0; wb_wen = 1'b0; flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs[i] = '0;
      arch[i] = '0;
    end
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_rd_wen = 1'b0; id_ctrl = '0;
    wb_wen = 1'b0; wb_waddr = '0; wb_wdata = '0;
    do_reset();

    // plain read after writeback
    wb(5, 32'h1234); cyc(); idle(); cyc();
    offer(5, 0, 6, 1); cyc(); idle(); cyc(); cyc();
    wb(6, 32'h66); cyc(); idle(); cyc();

    // RAW stall released by writeback with no extra bubble
    offer(1, 2, 3, 1); cyc();
    offer(3, 0, 0, 0); cyc();
    idle(); cyc(); cyc();
    wb(3, 32'hCAFE); cyc(); idle(); cyc(); cyc();

    // writeback on the accept edge must be bypassed
    wb(7, 32'h1111); cyc(); idle(); cyc();
    offer(0, 7, 0, 0); wb(7, 32'hBEEF); cyc(); idle(); cyc(); cyc();

    // back-pressure for four cycles with a second instruction waiting
    ex_ready = 1'b0;
    offer(1, 2, 0, 0); cyc();
    offer(2, 1, 0, 0);
    repeat (4) cyc();
    ex_ready = 1'b1; cyc();
    idle(); cyc(); cyc();

    // flush of a stalled consumer leaves the producer's pending bit set
    offer(0, 0, 9, 1); cyc();
    offer(9, 0, 0, 0); cyc();
    idle(); cyc();
    flush = 1'b1; cyc(); flush = 1'b0; cyc();
    offer(9, 0, 0, 0); cyc(); idle(); cyc(); cyc();
    wb(9, 32'h9999); cyc(); idle(); cyc(); cyc();

    // flush on the producer's issue edge still records it as pending
    offer(0, 0, 11, 1); cyc();
    idle(); flush = 1'b1; cyc(); flush = 1'b0;
    offer(11, 0, 0, 0); cyc(); idle(); cyc(); cyc();
    wb(11, 32'hB0B); cyc(); idle(); cyc(); cyc();

    // reset in the middle of a stall discards pending state
    offer(0, 0, 4, 1); cyc();
    offer(4, 0, 0, 0); cyc();
    idle(); cyc();
    ex_ready = 1'b0; cyc();
    do_reset();
    ex_ready = 1'b1;
    offer(4, 0, 0, 0); cyc(); idle(); cyc(); cyc();

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1_addr = 5'($urandom_range(0, 7));
      id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_addr  = 5'($urandom_range(0, 7));
      id_rd_wen   = $urandom_range(0, 1) == 1;
      id_ctrl     = {$urandom, $urandom};
      ex_ready    = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      wb_wen      = ($urandom_range(0, 2) == 0);
      wb_waddr    = 5'($urandom_range(0, 7));
      wb_wdata    = $urandom;
      cyc();
    end
    idle(); ex_ready = 1'b1; cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute operand stage that drives the synchronous-read register file and consumes its read data.
- Accepts one decoded instruction per cycle and presents source addresses to the register file in the accept cycle. Delivers operands to execute one cycle later.
- Tracks outstanding writers in a scoreboard and stalls RAW/WAW hazards.
- Bypasses the register-file write that lands on the same edge as the read, because the register file has no write-through.

Parameters:
XLEN, 32, datapath width (matches RV_BIT_NUM)
AW, 5, register address width (matches ADDR_BIT_NUM)
CTRL_W, 64, width of opaque control payload passed through to execute

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  drop held (not yet issued) instruction
id_valid  in  1  decode offers instruction
id_ready  out  1  stage can accept
id_rs1_addr  in  AW  source 1
id_rs2_addr  in  AW  source 2
id_rd_addr  in  AW  destination
id_rd_wen  in  1  instruction writes rd
id_ctrl  in  CTRL_W  passthrough payload
rf_rs1_addr  out  AW  to register file read port 1
rf_rs2_addr  out  AW  to register file read port 2
rf_rs1_data  in  XLEN  register file data, valid cycle after address
rf_rs2_data  in  XLEN  as above
wb_wen  in  1  writeback enable (same signal driving register file wen)
wb_waddr  in  AW  writeback address
wb_wdata  in  XLEN  writeback data
ex_valid  out  1  operands valid to execute
ex_ready  in  1  execute accepts
ex_rs1_data  out  XLEN  operand 1
ex_rs2_data  out  XLEN  operand 2
ex_rd_addr  out  AW  held rd
ex_rd_wen  out  1  held rd enable
ex_ctrl  out  CTRL_W  held payload

Behaviour:
- Reset (async, rst=1):
  - s_valid=0, scoreboard pending[31:0]=0, byp1_v=byp2_v=0.
  - ex_valid=0 and id_ready=1 immediately.
  - Held rs/rd/ctrl registers reset to 0.
  - Reset mid-operation discards the held instruction and clears all pending bits.
- Definitions:
  - ex_fire = ex_valid & ex_ready.
  - accept = id_valid & id_ready & ~flush.
  - id_ready = ~s_valid | ex_fire.
- Read addressing: rf_rsN_addr = accept ? id_rsN_addr : s_rsN. The held address is re-presented every cycle while stalled, so register-file data refreshes.
- Latency: accept at edge N sets s_valid. ex_valid can assert in cycle N+1 at earliest. Throughput is one instruction per cycle with no hazards.
- Bypass:
  - At every edge, byp_N_v <= wb_wen & (wb_waddr == rf_rsN_addr) & (wb_waddr != 0), and byp_N_d <= wb_wdata.
  - ex_rsN_data = (s_rsN == 0) ? 0 : byp_N_v ? byp_N_d : rf_rsN_data.
- Hazard (combinational, cycle where s_valid=1):
  - hazard = (s_rs1!=0 & pending[s_rs1]) | (s_rs2!=0 & pending[s_rs2]) | (s_rd_wen & s_rd!=0 & pending[s_rd]).
  - ex_valid = s_valid & ~hazard.
- Scoreboard:
  - Set: on ex_fire with s_rd_wen & s_rd!=0, pending[s_rd] <= 1.
  - Clear: on wb_wen & wb_waddr!=0, pending[wb_waddr] <= 0.
  - Same address set and clear on one edge: set wins.
  - Address 0 is never set.
- Hazard release: writeback at edge M clears the pending bit and loads the bypass register at edge M. ex_valid asserts in cycle M+1 with the bypassed value. No extra bubble.
- Back-to-back dependent instructions: the producer issues at edge N, and the consumer accepted at the same edge sees pending set in N+1 and stalls.
- Stall: all ex_* outputs hold stable while ex_valid & ~ex_ready. AXI-style rule: ex_valid never drops without ex_fire, except on flush or rst.
- Flush:
  - s_valid <= 0; no accept that cycle; id_ready is ignored.
  - Scoreboard is untouched, because issued instructions still write back.
  - Flush coinciding with ex_fire: the issue completes and its pending bit is set. Flush only blocks new accept.
- No FSM beyond s_valid (EMPTY/HOLD). HOLD->EMPTY on ex_fire without accept or on flush. EMPTY->HOLD on accept.

Decomposition:
- Shared package: XLEN, AW, NUM_REGS=2**AW, CTRL_W, and the flop/ctrl struct for the held instruction.
- One sub-module, of_scoreboard: pending bit vector with set/clear ports and two read-plus-one-rd lookup outputs.
- Bypass and handshake stay in operand_fetch.

Test Plan:
- Reset then write x5=0x1234 via wb. Issue add rs1=x5, rs2=x0 at a later cycle -> ex_valid next cycle, ex_rs1=0x1234, ex_rs2=0.
- Issue producer rd=x3 (ex_ready=1), consumer rs1=x3 next cycle -> consumer ex_valid=0 until wb x3=0xCAFE at edge M. ex_valid=1 at M+1 with ex_rs1=0xCAFE.
- Write x7=0xBEEF on the same edge the consumer with rs2=x7 is accepted (not pending) -> ex_rs2=0xBEEF via bypass, not stale.
- Hold ex_ready=0 for 4 cycles with valid instruction -> ex_* stable, id_ready=0. Release -> ex_fire once, next queued instruction follows next cycle.
- Pending x9, then flush while consumer held -> ex_valid=0 next cycle and pending[9] still 1. wb x9 clears it.
- Assert rst mid-stall with pending[4]=1 -> ex_valid=0, id_ready=1 immediately. Instruction reading x4 afterwards issues without stall.
